// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory path: RAM geometry used by both
// the loader and the instruction RAM, plus the loader state encoding.
package imem_loader_pkg;

  localparam int IMEM_DEPTH  = 256;
  localparam int IMEM_ADDR_W = 8;
  localparam int LEN_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } ld_state_t;

  // The CPU stays in reset while a load is running or after it failed.
  function automatic logic holds_cpu(input ld_state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Serial boot loader: receives a 16-bit big-endian word count followed by
// big-endian 32-bit words and writes them into the instruction RAM from
// address 0 while holding the CPU in reset.
//
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data; there is no
// ready/back-pressure, so every strobe seen in LEN_HI/LEN_LO/DATA is consumed
// and strobes in any other state are dropped.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH   = IMEM_DEPTH,
  parameter int ADDR_W  = IMEM_ADDR_W,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output ld_state_t         state_dbg
);

  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [LEN_W:0]  DEPTH_L = (LEN_W + 1)'(DEPTH);

  ld_state_t          state, state_nxt;
  logic [LEN_W-1:0]   len_q;
  logic [1:0]         byte_cnt;
  logic [ADDR_W:0]    word_idx;
  logic [23:0]        shift_q;
  logic [CNT_W-1:0]   idle_cnt;
  logic               we_q;

  logic               loading;
  logic               restart;
  logic               timeout_hit;
  logic [LEN_W-1:0]   n_rx;
  logic               len_bad;
  logic               last_write;

  // Decode of the conditions that drive both the FSM and the datapath.
  always_comb begin
    loading     = (state == ST_LEN_HI) || (state == ST_LEN_LO) || (state == ST_DATA);
    restart     = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    timeout_hit = loading && !rx_valid && (idle_cnt == TO_LAST);
    n_rx        = {len_q[15:8], rx_data};
    len_bad     = (n_rx == '0) || ({1'b0, n_rx} > DEPTH_L);
    // The word index was bumped when the pulse was scheduled, so during the
    // pulse it already equals the number of words written.
    last_write  = (state == ST_DATA) && we_q && (LEN_W'(word_idx) == len_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_nxt = ST_LEN_HI;
      ST_LEN_HI: begin
        if (rx_valid)         state_nxt = ST_LEN_LO;
        else if (timeout_hit) state_nxt = ST_ERR;
      end
      ST_LEN_LO: begin
        if (rx_valid)         state_nxt = len_bad ? ST_ERR : ST_DATA;
        else if (timeout_hit) state_nxt = ST_ERR;
      end
      ST_DATA: begin
        if (last_write)       state_nxt = ST_DONE;
        else if (timeout_hit) state_nxt = ST_ERR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Length capture, word assembly, write scheduling and the idle timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q    <= '0;
      byte_cnt <= '0;
      word_idx <= '0;
      shift_q  <= '0;
      idle_cnt <= '0;
      we_q     <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
    end else begin
      we_q <= 1'b0;
      if (restart) begin
        len_q    <= '0;
        byte_cnt <= '0;
        word_idx <= '0;
        idle_cnt <= '0;
      end else if (loading) begin
        if (rx_valid) idle_cnt <= '0;
        else          idle_cnt <= idle_cnt + 1'b1;
        if (rx_valid) begin
          case (state)
            ST_LEN_HI: len_q[15:8] <= rx_data;
            ST_LEN_LO: len_q[7:0]  <= rx_data;
            ST_DATA: begin
              byte_cnt <= byte_cnt + 2'd1;
              shift_q  <= {shift_q[15:0], rx_data};
              if (byte_cnt == 2'd3) begin
                we_q     <= 1'b1;
                waddr    <= word_idx[ADDR_W-1:0];
                wdata    <= {shift_q, rx_data};
                word_idx <= word_idx + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Reset gates the pulse combinationally so a write scheduled just before
  // reset never reaches the RAM.
  always_comb begin
    we        = we_q && !reset;
    cpu_hold  = holds_cpu(state);
    done      = (state == ST_DONE);
    err       = (state == ST_ERR);
    state_dbg = state;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and randomized loads checked against a
// byte-stream model of the load protocol.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset, start, rx_valid;
  logic [7:0]  rx_data;
  logic        we, cpu_hold, done, err;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  ld_state_t   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  tx_q[$];
  logic [39:0] exp_q[$];
  logic [40:0] got_q[$];
  bit          exp_err;

  // Clock / reset
  always #5 clk = ~clk;

  imem_loader #(.DEPTH(256), .ADDR_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .we(we), .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold), .done(done),
    .err(err), .state_dbg(state_dbg)
  );

  // Capture every write pulse together with cpu_hold.
  always @(negedge clk) begin
    if (we === 1'b1) got_q.push_back({cpu_hold, waddr, wdata});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) step();
    rx_valid = 1'b1; rx_data = b;
    step();
    rx_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  // Reference model: word count then big-endian words written from address 0.
  task automatic build_model();
    int n;
    exp_q.delete();
    n = int'({tx_q[0], tx_q[1]});
    exp_err = (n == 0) || (n > 256);
    if (!exp_err)
      for (int i = 0; i < n; i++)
        exp_q.push_back({8'(i), tx_q[2+4*i], tx_q[3+4*i], tx_q[4+4*i], tx_q[5+4*i]});
  endtask

  task automatic make_load(input int n, input int nwords);
    tx_q.delete();
    tx_q.push_back(8'(n >> 8));
    tx_q.push_back(8'(n));
    for (int i = 0; i < 4 * nwords; i++) tx_q.push_back(8'($urandom));
  endtask

  task automatic run_load(input string name, input int gapmax);
    int k;
    build_model();
    got_q.delete();
    pulse_start();
    n_checks++;
    if (cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_start: hold/done/err=%b%b%b want 100", name, cpu_hold, done, err);
    end
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], $urandom_range(gapmax, 0));
    if (!exp_err) begin
      @(negedge clk);
      n_checks++;
      if (we !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_last_pulse: we/hold/done=%b%b%b want 110", name, we, cpu_hold, done);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b1 || we !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_done_timing: done/we=%b%b want 10", name, done, we);
      end
    end
    k = 0;
    while (!(done === 1'b1 || err === 1'b1) && k < 40) begin
      @(negedge clk); k++;
    end
    n_checks++;
    if (k >= 40) begin
      n_fail++;
      $display("FAIL %s_wait: no done/err within 40 cycles", name);
    end
    n_checks++;
    if (done !== !exp_err || err !== exp_err || cpu_hold !== exp_err) begin
      n_fail++;
      $display("FAIL %s_flags: done/err/hold=%b%b%b want %b%b%b", name, done, err, cpu_hold,
               !exp_err, exp_err, exp_err);
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d writes want %0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== {1'b1, exp_q[i]}) begin
          n_fail++;
          $display("FAIL %s_write%0d: got hold/addr/data %h want 1/%h", name, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({we, waddr, wdata, cpu_hold, done, err} !== '0 || state_dbg !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_outputs: we=%b waddr=%h wdata=%h hold=%b done=%b err=%b st=%0d want all 0",
               we, waddr, wdata, cpu_hold, done, err, state_dbg);
    end
  endtask

  task automatic test_idle_start_priority();
    got_q.delete();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1);
    n_checks++;
    if (got_q.size() != 0 || state_dbg !== ST_IDLE || cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignore: writes=%0d st=%0d hold=%b want 0/IDLE/0", got_q.size(), state_dbg, cpu_hold);
    end
    // start and a byte together: the byte must be dropped.
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'h00;
    step();
    start = 1'b0; rx_valid = 1'b0;
    tx_q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    build_model();
    send_byte(tx_q[0], 0);
    // start mid-load is ignored.
    pulse_start();
    for (int i = 1; i < tx_q.size(); i++) send_byte(tx_q[i], 0);
    repeat (3) step();
    n_checks++;
    if (done !== 1'b1 || got_q.size() != 1) begin
      n_fail++;
      $display("FAIL start_priority: done=%b writes=%0d want 1/1", done, got_q.size());
    end else begin
      n_checks++;
      if (got_q[0] !== {1'b1, 8'h00, 32'hDEADBEEF}) begin
        n_fail++;
        $display("FAIL start_priority_word: got %h want 1_00_deadbeef", got_q[0]);
      end
    end
  endtask

  task automatic test_normal();
    tx_q = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h62, 8'h61, 8'h34, 8'h24, 8'h61, 8'h63};
    run_load("normal", 2);
    n_checks++;
    if (got_q.size() != 2 || got_q[0][31:0] !== 32'h3C016261 || got_q[1][39:0] !== 40'h01_34246163) begin
      n_fail++;
      $display("FAIL normal_words: n=%0d w0=%h w1=%h want 2/3c016261/01_34246163",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 41'h0, got_q.size() > 1 ? got_q[1] : 41'h0);
    end
  endtask

  task automatic test_bad_len();
    tx_q = '{8'h01, 8'h01};
    run_load("bad_len_257", 3);
    tx_q = '{8'h00, 8'h00};
    run_load("bad_len_0", 3);
    got_q.delete();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    n_checks++;
    if (got_q.size() != 0 || err !== 1'b1 || state_dbg !== ST_ERR) begin
      n_fail++;
      $display("FAIL err_ignore_rx: writes=%0d err=%b st=%0d want 0/1/ERR", got_q.size(), err, state_dbg);
    end
  endtask

  task automatic test_timeout();
    got_q.delete();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'hAC, 0); send_byte(8'h04, 0);
    repeat (TO - 1) step();
    n_checks++;
    if (err !== 1'b0 || state_dbg !== ST_DATA) begin
      n_fail++;
      $display("FAIL timeout_early: err=%b st=%0d want 0/DATA after %0d idle", err, state_dbg, TO - 1);
    end
    step();
    n_checks++;
    if (err !== 1'b1 || cpu_hold !== 1'b1 || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_err: err=%b hold=%b writes=%0d want 1/1/0", err, cpu_hold, got_q.size());
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      if (t % 4 == 3) make_load($urandom_range(65535, 257), 0);
      else begin
        int n;
        n = $urandom_range(6, 1);
        make_load(n, n);
      end
      run_load($sformatf("rand%0d", t), 4);
    end
  endtask

  task automatic test_full_depth();
    make_load(256, 256);
    run_load("full", 0);
    n_checks++;
    if (got_q.size() == 0 || got_q[got_q.size()-1][39:32] !== 8'hFF) begin
      n_fail++;
      $display("FAIL full_last_addr: n=%0d last=%h want addr ff", got_q.size(),
               got_q.size() > 0 ? got_q[got_q.size()-1] : 41'h0);
    end
  endtask

  task automatic test_reset_mid();
    got_q.delete();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_we: got %b want 0", we);
    end
    step();
    reset = 1'b0;
    n_checks++;
    if ({we, waddr, wdata, cpu_hold, done, err} !== '0 || state_dbg !== ST_IDLE || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_state: we=%b waddr=%h wdata=%h hold=%b done=%b err=%b st=%0d writes=%0d want 0/IDLE",
               we, waddr, wdata, cpu_hold, done, err, state_dbg, got_q.size());
    end
  endtask

  task automatic test_restart();
    make_load(3, 3);
    run_load("first", 1);
    make_load(1, 1);
    run_load("restart", 1);
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_idle_start_priority();
    test_normal();
    test_bad_len();
    test_timeout();
    test_random();
    test_full_depth();
    test_reset_mid();
    test_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit instruction words in the target instruction RAM.
REQ-002 SHALL have parameter ADDR_W, default 8, word-address width; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter TIMEOUT, default 1000000, max idle clk cycles between bytes during a load.
REQ-004 SHALL have port clk  input  1  system clock; one clock only, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-007 SHALL have port rx_data  input  8  byte from the serial receiver.
REQ-008 SHALL have port rx_valid  input  1  rx_data valid this cycle; one-cycle strobe per byte, no back-pressure.
REQ-009 SHALL have port we  output  1  instruction-RAM write enable, one-cycle pulse per word.
REQ-010 SHALL have port waddr  output  ADDR_W  word address (equals Address[9:2] on the CPU fetch side).
REQ-011 SHALL have port wdata  output  32  instruction word to write.
REQ-012 SHALL have port cpu_hold  output  1  holds the CPU pipeline in reset while high.
REQ-013 SHALL have ports done and err  output  1 each  sticky load-complete and load-failed flags.

Function
REQ-014 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR.
REQ-015 SHALL leave IDLE, DONE or ERR for LEN_HI on start, clearing done, err, byte and word counters; start in LEN_HI/LEN_LO/DATA SHALL be ignored.
REQ-016 SHALL capture the word count N as a 16-bit big-endian value: first accepted byte in LEN_HI (high byte), next in LEN_LO (low byte).
REQ-017 SHALL, after LEN_LO, enter ERR if N == 0 or N > DEPTH, else DATA.
REQ-018 SHALL assemble each word big-endian from four accepted bytes (first byte -> wdata[31:24]).
REQ-019 SHALL assert we for exactly one cycle, the cycle after the fourth byte of a word, with waddr = word index (0..N-1) and wdata = assembled word, both stable during that cycle.
REQ-020 SHALL increment the word index after each write and enter DONE in the cycle of the N-th write's we pulse + 1, setting done=1.
REQ-021 SHALL drive cpu_hold=1 in LEN_HI, LEN_LO, DATA and ERR, and 0 in IDLE and DONE; the final we pulse SHALL occur while cpu_hold=1.
REQ-022 SHALL count idle cycles since the last accepted byte (or since start) in LEN_HI/LEN_LO/DATA and enter ERR with err=1 when the count reaches TIMEOUT; a partially assembled word SHALL NOT be written.
REQ-023 SHALL ignore rx_valid in IDLE, DONE and ERR (no writes, no state change).
REQ-024 SHALL hold we=0 whenever not producing a REQ-019 pulse; waddr/wdata may hold last values.
REQ-025 SHALL, on start and rx_valid in the same cycle in IDLE/DONE/ERR, take start and discard the byte.

Reset
REQ-026 SHALL, on reset, enter IDLE with we=0, waddr=0, wdata=0, cpu_hold=0, done=0, err=0, all counters 0.
REQ-027 SHALL honour reset mid-load immediately (next edge), abandoning the load and suppressing any pending we pulse.

Structure
REQ-028 SHALL take state encoding and the DEPTH/ADDR_W defaults from the shared pipeline package, so the instruction RAM uses the same constants.
REQ-029 SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-030 SHALL verify normal load: start, bytes 00 02 3C 01 62 61 34 24 61 63 -> we pulses waddr=0 wdata=3C016261, waddr=1 wdata=34246163, then done=1, cpu_hold=0.
REQ-031 SHALL verify bad length: start, bytes 01 01 (N=257) -> ERR, err=1, cpu_hold=1, no we pulse.
REQ-032 SHALL verify timeout: TIMEOUT=16, start, bytes 00 01 AC 04, then 16 idle cycles -> err=1, no we pulse.
REQ-033 SHALL verify full-depth load N=256 (00 00 rejected as N=0; send 01 00): last write waddr=FF, done=1.
REQ-034 SHALL verify reset asserted on the cycle after the 4th byte of a word -> no we pulse, IDLE, all outputs 0.
REQ-035 SHALL verify restart from DONE: second start clears done, cpu_hold=1, new load overwrites waddr=0.
